// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the MEM-stage data-memory port,
// store lane steering, load extraction and a retired-instruction counter.
module ex_mem_wb_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_mem,
    input  logic             flush_ex,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_mem_to_reg,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [3:0]       mem_wstrb,
    output logic             mem_read,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [4:0]       rd_mem,
    output logic             reg_write_mem,
    output logic [XLEN-1:0]  alu_result_mem,
    output logic [4:0]       rd_wb,
    output logic             reg_write_wb,
    output logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] instret
);
    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
    } exm_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_to_reg;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] ld;
    } mwb_t;

    exm_t exm, ex_in;
    mwb_t mwb;
    logic [1:0]      lane;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] st_data;
    logic [3:0]      st_strb;

    assign ex_in = '{valid: ex_valid, rd: ex_rd, reg_write: ex_reg_write,
                     mem_read: ex_mem_read, mem_write: ex_mem_write,
                     mem_to_reg: ex_mem_to_reg, funct3: ex_funct3,
                     alu: ex_alu_result, rs2: ex_rs2_data};

    // A flushed slot is registered as all-zero so the bubble carries no stale fields.
    always_ff @(posedge clk) begin
        if (!reset)
            exm <= '0;
        else if (!stall_mem)
            exm <= flush_ex ? '0 : ex_in;
    end

    assign lane = exm.alu[1:0];
    assign ld_b = mem_rdata[{lane, 3'b000} +: 8];
    assign ld_h = mem_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = mem_rdata;
        case (exm.funct3)
            3'b000:  ld_data = {{(XLEN-8){ld_b[7]}}, ld_b};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_b};
            3'b001:  ld_data = {{(XLEN-16){ld_h[15]}}, ld_h};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_h};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        st_data = exm.rs2;
        st_strb = 4'b1111;
        case (exm.funct3[1:0])
            2'b00: begin
                st_data = XLEN'({4{exm.rs2[7:0]}});
                st_strb = 4'b0001 << lane;
            end
            2'b01: begin
                st_data = XLEN'({2{exm.rs2[15:0]}});
                st_strb = 4'b0011 << {lane[1], 1'b0};
            end
            default: ;
        endcase
    end

    // A stall retires nothing: MEM/WB gets a bubble while rd/data keep their last values.
    always_ff @(posedge clk) begin
        if (!reset)
            mwb <= '0;
        else if (stall_mem)
            mwb.valid <= 1'b0;
        else
            mwb <= '{valid: exm.valid, rd: exm.rd, reg_write: exm.reg_write,
                     mem_to_reg: exm.mem_to_reg, alu: exm.alu, ld: ld_data};
    end

    always_ff @(posedge clk) begin
        if (!reset)
            instret <= '0;
        else if (mwb.valid)
            instret <= instret + CNT_W'(1);
    end

    assign mem_addr       = exm.alu;
    assign mem_wdata      = st_data;
    assign mem_wstrb      = (exm.valid && exm.mem_write) ? st_strb : 4'b0000;
    assign mem_read       = exm.valid & exm.mem_read;
    assign rd_mem         = exm.rd;
    assign reg_write_mem  = exm.valid & exm.reg_write;
    assign alu_result_mem = exm.alu;
    assign rd_wb          = mwb.rd;
    assign reg_write_wb   = mwb.valid & mwb.reg_write;
    assign wb_data        = mwb.mem_to_reg ? mwb.ld : mwb.alu;
endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed bench for ex_mem_wb_pipe: a cycle-by-cycle vector table followed by
// hand-written stall, flush, stall+flush and reset-during-load sequences.
module tb_ex_mem_wb_pipe;
    logic        clk = 1'b0;
    logic        reset, stall_mem, flush_ex, ex_valid, ex_reg_write;
    logic        ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_rs2_data, mem_rdata;
    logic [31:0] mem_addr, mem_wdata, alu_result_mem, wb_data, instret;
    logic [3:0]  mem_wstrb;
    logic        mem_read, reg_write_mem, reg_write_wb;
    logic [4:0]  rd_mem, rd_wb;

    int n_run = 0;
    int n_fail = 0;

    ex_mem_wb_pipe #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall_mem(stall_mem), .flush_ex(flush_ex),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_funct3(ex_funct3),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_read(mem_read), .mem_rdata(mem_rdata), .rd_mem(rd_mem),
        .reg_write_mem(reg_write_mem), .alu_result_mem(alu_result_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .wb_data(wb_data),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, stall, flush, v, rw, mr, mw, m2r;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] alu, rs2, rdata;
        logic [4:0]  e_rdm, e_rdw;
        logic        e_rwm, e_mrd, e_rww;
        logic [3:0]  e_strb;
        logic [31:0] e_alum, e_wdat, e_wb, e_ir;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_mem = 0; flush_ex = 0; ex_valid = 0; ex_rd = 0; ex_reg_write = 0;
        ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0; ex_funct3 = 0;
        ex_alu_result = 0; ex_rs2_data = 0;
    endtask

    task automatic drive(vec_t t);
        reset = t.rst_n; stall_mem = t.stall; flush_ex = t.flush; ex_valid = t.v;
        ex_rd = t.rd; ex_reg_write = t.rw; ex_mem_read = t.mr; ex_mem_write = t.mw;
        ex_mem_to_reg = t.m2r; ex_funct3 = t.f3; ex_alu_result = t.alu;
        ex_rs2_data = t.rs2; mem_rdata = t.rdata;
    endtask

    initial begin
        // reset held two cycles with a live instruction presented
        vecs[0]  = '{default: '0, v: 1, rw: 1, rd: 5};
        vecs[1]  = '{default: '0, v: 1, rw: 1, rd: 5};
        vecs[2]  = '{default: '0, rst_n: 1, v: 1, rw: 1, rd: 5, alu: 32'h55,
                     e_rdm: 5, e_rwm: 1, e_alum: 32'h55};
        // back-to-back ALU ops
        vecs[3]  = '{default: '0, rst_n: 1, v: 1, rw: 1, rd: 3, alu: 32'h11,
                     e_rdm: 3, e_rwm: 1, e_alum: 32'h11, e_rdw: 5, e_rww: 1, e_wb: 32'h55};
        vecs[4]  = '{default: '0, rst_n: 1, v: 1, rw: 1, rd: 4, alu: 32'h22,
                     e_rdm: 4, e_rwm: 1, e_alum: 32'h22, e_rdw: 3, e_rww: 1, e_wb: 32'h11, e_ir: 1};
        vecs[5]  = '{default: '0, rst_n: 1, e_rdw: 4, e_rww: 1, e_wb: 32'h22, e_ir: 2};
        vecs[6]  = '{default: '0, rst_n: 1, e_ir: 3};
        vecs[7]  = '{default: '0, rst_n: 1, e_ir: 3};
        // LB then LBU at 0x1003
        vecs[8]  = '{default: '0, rst_n: 1, v: 1, rw: 1, rd: 6, mr: 1, m2r: 1, f3: 3'b000,
                     alu: 32'h1003, e_rdm: 6, e_rwm: 1, e_alum: 32'h1003, e_mrd: 1, e_ir: 3};
        vecs[9]  = '{default: '0, rst_n: 1, v: 1, rw: 1, rd: 7, mr: 1, m2r: 1, f3: 3'b100,
                     alu: 32'h1003, rdata: 32'h80FF_0000, e_rdm: 7, e_rwm: 1,
                     e_alum: 32'h1003, e_mrd: 1, e_rdw: 6, e_rww: 1, e_wb: 32'hFFFF_FF80, e_ir: 3};
        vecs[10] = '{default: '0, rst_n: 1, rdata: 32'h80FF_0000,
                     e_rdw: 7, e_rww: 1, e_wb: 32'h0000_0080, e_ir: 4};
        // SH at 0x2002, SB at 0x2001
        vecs[11] = '{default: '0, rst_n: 1, v: 1, mw: 1, f3: 3'b001, alu: 32'h2002,
                     rs2: 32'h1234_ABCD, e_alum: 32'h2002, e_strb: 4'b1100,
                     e_wdat: 32'hABCD_ABCD, e_ir: 5};
        vecs[12] = '{default: '0, rst_n: 1, v: 1, mw: 1, f3: 3'b000, alu: 32'h2001,
                     rs2: 32'h1234_ABCD, e_alum: 32'h2001, e_strb: 4'b0010,
                     e_wdat: 32'hCDCD_CDCD, e_wb: 32'h2002, e_ir: 5};
        vecs[13] = '{default: '0, rst_n: 1, e_wb: 32'h2001, e_ir: 6};
        vecs[14] = '{default: '0, rst_n: 1, e_ir: 7};

        drive(vecs[0]);
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d rd_mem", i), 32'(rd_mem), 32'(vecs[i].e_rdm));
            chk($sformatf("v%0d reg_write_mem", i), 32'(reg_write_mem), 32'(vecs[i].e_rwm));
            chk($sformatf("v%0d alu_result_mem", i), alu_result_mem, vecs[i].e_alum);
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_alum);
            chk($sformatf("v%0d mem_read", i), 32'(mem_read), 32'(vecs[i].e_mrd));
            chk($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_strb));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdat);
            chk($sformatf("v%0d rd_wb", i), 32'(rd_wb), 32'(vecs[i].e_rdw));
            chk($sformatf("v%0d reg_write_wb", i), 32'(reg_write_wb), 32'(vecs[i].e_rww));
            chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_wb);
            chk($sformatf("v%0d instret", i), instret, vecs[i].e_ir);
        end

        // LH held in EX/MEM across a 3-cycle stall
        idle(); ex_valid = 1; ex_rd = 9; ex_reg_write = 1; ex_mem_read = 1;
        ex_mem_to_reg = 1; ex_funct3 = 3'b001; ex_alu_result = 32'h3002;
        tick();
        chk("lh issue mem_read", 32'(mem_read), 32'd1);
        stall_mem = 1; ex_rd = 12; ex_alu_result = 32'h99; ex_mem_read = 0;
        ex_mem_to_reg = 0; ex_funct3 = 0; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d rd_mem", i), 32'(rd_mem), 32'd9);
            chk($sformatf("stall%0d mem_addr", i), mem_addr, 32'h3002);
            chk($sformatf("stall%0d mem_read", i), 32'(mem_read), 32'd1);
            chk($sformatf("stall%0d reg_write_wb", i), 32'(reg_write_wb), 32'd0);
        end
        idle(); mem_rdata = 32'h8001_1234;
        tick();
        chk("stall release rd_wb", 32'(rd_wb), 32'd9);
        chk("stall release reg_write_wb", 32'(reg_write_wb), 32'd1);
        chk("stall release wb_data", wb_data, 32'hFFFF_8001);
        chk("stall release instret", instret, 32'd7);
        tick();
        chk("lh retired instret", instret, 32'd8);
        chk("lh retired reg_write_wb", 32'(reg_write_wb), 32'd0);

        // flushed instruction never writes back or retires
        idle(); ex_valid = 1; ex_reg_write = 1; ex_rd = 7; ex_alu_result = 32'h77; flush_ex = 1;
        tick();
        chk("flush reg_write_mem", 32'(reg_write_mem), 32'd0);
        idle();
        tick();
        chk("flush reg_write_wb", 32'(reg_write_wb), 32'd0);
        tick();
        chk("flush instret", instret, 32'd8);

        // stall and flush together: stall wins, EX/MEM instruction survives
        idle(); ex_valid = 1; ex_reg_write = 1; ex_rd = 10; ex_alu_result = 32'hAA;
        tick();
        stall_mem = 1; flush_ex = 1; ex_rd = 11; ex_alu_result = 32'hBB;
        tick();
        chk("stall+flush rd_mem", 32'(rd_mem), 32'd10);
        chk("stall+flush reg_write_mem", 32'(reg_write_mem), 32'd1);
        chk("stall+flush alu_result_mem", alu_result_mem, 32'hAA);
        chk("stall+flush reg_write_wb", 32'(reg_write_wb), 32'd0);
        stall_mem = 0;
        tick();
        chk("flush after stall reg_write_mem", 32'(reg_write_mem), 32'd0);
        chk("flush after stall rd_wb", 32'(rd_wb), 32'd10);
        chk("flush after stall reg_write_wb", 32'(reg_write_wb), 32'd1);
        chk("flush after stall wb_data", wb_data, 32'hAA);
        idle();
        tick();
        chk("stall+flush instret", instret, 32'd9);

        // reset while a stalled load is pending discards it
        idle(); ex_valid = 1; ex_rd = 13; ex_reg_write = 1; ex_mem_read = 1;
        ex_mem_to_reg = 1; ex_funct3 = 3'b010; ex_alu_result = 32'h4000;
        tick();
        stall_mem = 1; reset = 0;
        tick();
        chk("mid-load reset mem_read", 32'(mem_read), 32'd0);
        chk("mid-load reset rd_mem", 32'(rd_mem), 32'd0);
        chk("mid-load reset mem_addr", mem_addr, 32'd0);
        chk("mid-load reset rd_wb", 32'(rd_wb), 32'd0);
        chk("mid-load reset wb_data", wb_data, 32'd0);
        chk("mid-load reset instret", instret, 32'd0);
        reset = 1; idle();
        tick();
        chk("post reset reg_write_wb", 32'(reg_write_wb), 32'd0);
        chk("post reset instret", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mem_wb_pipe.md
Name: ex_mem_wb_pipe

Overview:
- Two-stage back-end pipeline: the EX/MEM register, the MEM-stage data-memory interface with load extraction, and the MEM/WB register.
- Produces the rd/RegWrite pairs that the forwarding unit compares against ID/EX rs1/rs2: rd_mem/reg_write_mem (select 2'b10) and rd_wb/reg_write_wb (select 2'b01).
- Also produces the matching forwarded data, alu_result_mem and wb_data.
- Sits between the EX-stage ALU and the register file write port.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; clears all state when sampled low on a clk rising edge.
- stall_mem  in  1  memory not ready: hold EX/MEM, inject a bubble into MEM/WB.
- flush_ex  in  1  squash the instruction currently in EX (branch mispredict); it enters EX/MEM as a bubble.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  RegWrite control.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_mem_to_reg  in  1  writeback selects load data.
- ex_funct3  in  3  load/store size and sign.
- ex_alu_result  in  XLEN  ALU result / effective address.
- ex_rs2_data  in  XLEN  store data, already forwarded.
- mem_addr  out  XLEN  data-memory address (= EX/MEM alu_result).
- mem_wdata  out  XLEN  store data, lane-replicated.
- mem_wstrb  out  4  byte write strobes.
- mem_read  out  1  load request.
- mem_rdata  in  XLEN  word read data, combinational in the same cycle as mem_addr.
- rd_mem  out  5  EX/MEM.rd.
- reg_write_mem  out  1  EX/MEM.RegWrite & valid.
- alu_result_mem  out  XLEN  EX/MEM forward data.
- rd_wb  out  5  MEM/WB.rd.
- reg_write_wb  out  1  MEM/WB.RegWrite & valid; also the register file write enable.
- wb_data  out  XLEN  writeback / forward data.
- instret  out  CNT_W  count of instructions retired through MEM/WB.

Behaviour:
- Reset (reset=0 at edge): both valid bits 0, all rd fields 0, all data registers 0, instret 0.
  - Consequence: every output is 0 the cycle after reset, including reg_write_mem, reg_write_wb, mem_read and mem_wstrb.
  - Reset has priority over stall_mem and flush_ex.
  - Reset mid-load discards the load.
- Latency: an EX-stage instruction appears on the *_mem outputs one cycle later and on the *_wb outputs two cycles later, absent stalls.
- EX/MEM update, in priority order:
  - stall_mem=1: hold all fields.
  - flush_ex=1: valid<=0; other fields don't-care; registering 0 is preferred.
  - Otherwise: capture all ex_* fields; valid<=ex_valid.
- MEM/WB update, in priority order:
  - stall_mem=1: valid<=0 (bubble); rd and data hold.
  - Otherwise: capture valid, rd, reg_write, mem_to_reg, the alu_result and the extracted load data.
- stall_mem and flush_ex together: stall wins. The instruction held in EX/MEM is unaffected, and the upstream stall logic must keep the flush asserted until the stall releases.
- All control outputs are gated with their stage valid bit: reg_write_*, mem_read, mem_wstrb.
- rd_* are ungated; downstream logic relies only on reg_write_* and rd!=0.
- Memory requests are issued only while EX/MEM.valid=1. During stall_mem, mem_read/mem_wstrb stay asserted, i.e. the request is held stable.
- Store lane logic, with a = mem_addr[1:0]:
  - SB (funct3 000): wdata = {4{rs2[7:0]}}, wstrb = 0001<<a.
  - SH (001): wdata = {2{rs2[15:0]}}, wstrb = 0011<<{a[1],1'b0}.
  - SW (010): wdata = rs2, wstrb = 1111.
  - Misaligned accesses are not trapped; low address bits are ignored beyond the lane select.
- Load extraction, computed in MEM from mem_rdata and addr[1:0] and registered into MEM/WB:
  - LB (000) / LBU (100): byte at lane a, sign- / zero-extended.
  - LH (001) / LHU (101): half at a[1], sign- / zero-extended.
  - LW (010): whole word.
  - Other funct3 values: whole word.
- wb_data = mem_to_reg ? load_data_wb : alu_result_wb, combinational from MEM/WB.
- instret increments by 1 on each edge where MEM/WB.valid=1 (not reset), i.e. per retired instruction including bubbles-free stores.
  - Wraps modulo 2^CNT_W with no saturation.
- A load in EX/MEM exposes alu_result_mem, not load data. Load-use stalls are the responsibility of the hazard unit upstream.

Test Plan:
- Reset low 2 cycles with ex_valid=1, ex_reg_write=1, ex_rd=5 -> all outputs 0; after release, first instruction seen at rd_mem=5 / reg_write_mem=1 one cycle later, and at rd_wb=5 two cycles later.
- Back-to-back ALU ops: rd=3 with result 0x11, then rd=4 with result 0x22 -> cycle n+1: rd_mem=3, alu_result_mem=0x11; cycle n+2: rd_mem=4, rd_wb=3, wb_data=0x11; instret=2 after both retire.
- LB at addr 0x1003 with mem_rdata=0x80FF_0000, then LBU at the same address -> wb_data=0xFFFF_FF80, then 0x0000_0080.
- SH at addr 0x2002 with rs2=0x1234_ABCD -> mem_wdata=0xABCD_ABCD, mem_wstrb=1100; SB at addr 0x2001 -> mem_wstrb=0010.
- stall_mem high 3 cycles with a load in EX/MEM -> rd_mem/mem_addr held, mem_read=1 throughout, reg_write_wb=0 for 3 cycles; on release, load data is written one cycle later.
- flush_ex with ex_valid=1, ex_reg_write=1, rd=7 -> next cycle reg_write_mem=0, and reg_write_wb=0 the cycle after; instret is not incremented for the flushed instruction.
